// File: rtl/clint_arbiter.sv
// clint_arbiter: two-requester arbiter in front of the CLINT timer registers.
// Each transaction is a fixed three-cycle sequence: IDLE (arbitrate and latch),
// ACCESS (grant pulse, drive the timer port, capture read data), and RESP
// (response pulse to the winner).
//
// Optional feature macro: CLINT_ARB_RR_EN
//   defined   -> round-robin tie-break (the requester not granted last wins)
//   undefined -> fixed priority (m0 wins ties), no pointer register
//
// Timer register addresses come from `ADDR_MTIME / `ADDR_MTIMECMP. Standard
// CLINT offsets are provided here when the including build has not set them.
//
// Handshake: a requester holds mk_req and its payload stable until it sees
// mk_gnt. Dropping mk_req before the grant withdraws the request and no
// response is produced. mk_gnt and mk_rvalid are single-cycle pulses.
// mk_rdata and mk_rerr are meaningful only while mk_rvalid=1 and read 0
// otherwise.

`ifndef ADDR_MTIMECMP
`define ADDR_MTIMECMP 64'h0000_0000_0200_4000
`endif
`ifndef ADDR_MTIME
`define ADDR_MTIME 64'h0000_0000_0200_BFF8
`endif

module clint_arbiter #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [63:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [63:0]       m0_rdata,
    output logic              m0_rerr,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [63:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [63:0]       m1_rdata,
    output logic              m1_rerr,

    output logic              tmr_cen_o,
    output logic              tmr_wen_o,
    output logic [ADDR_W-1:0] tmr_addr_o,
    output logic [63:0]       tmr_wdata_o,
    input  logic [63:0]       tmr_rdata_i,

    // Current FSM state (IDLE=0, ACCESS=1, RESP=2), for observation only.
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] MTIME_ADDR    = ADDR_W'(`ADDR_MTIME);
    localparam logic [ADDR_W-1:0] MTIMECMP_ADDR = ADDR_W'(`ADDR_MTIMECMP);

    state_t            state_q;
    state_t            state_d;

    // Latched transaction: winner index (0=m0, 1=m1) and its payload.
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;

    // Response captured during ACCESS, presented during RESP.
    logic [63:0]       resp_q;
    logic              rerr_q;

    logic              any_req;
    logic              win_d;
    logic              mapped;

    assign any_req   = m0_req | m1_req;
    assign mapped    = (addr_q == MTIME_ADDR) || (addr_q == MTIMECMP_ADDR);
    assign fsm_state = state_q;

`ifdef CLINT_ARB_RR_EN
    // Index of the requester that wins the next tie; reset prefers m0.
    logic pref_q;

    // Hand preference to the other requester after every grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pref_q <= 1'b0;
        end else if (state_q == ACCESS) begin
            pref_q <= ~win_q;
        end
    end
`endif

    // Pick the winner among the current requesters.
    always_comb begin
        win_d = 1'b0;
        if (m0_req && m1_req) begin
`ifdef CLINT_ARB_RR_EN
            win_d = pref_q;
`else
            win_d = 1'b0;
`endif
        end else if (m1_req) begin
            win_d = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a transaction always walks IDLE -> ACCESS -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner's payload in IDLE and capture the response in ACCESS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_q   <= win_d;
                        we_q    <= win_d ? m1_we    : m0_we;
                        addr_q  <= win_d ? m1_addr  : m0_addr;
                        wdata_q <= win_d ? m1_wdata : m0_wdata;
                    end
                end
                ACCESS: begin
                    // Writes and unmapped reads return zero data.
                    resp_q <= (mapped && !we_q) ? tmr_rdata_i : 64'd0;
                    rerr_q <= ~mapped;
                end
                default: ;
            endcase
        end
    end

    // Decode outputs from the state. Everything is held at zero while
    // rst_n is low so an aborted ACCESS never strobes the timer and an
    // aborted RESP never delivers a response.
    always_comb begin
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        m0_rdata    = 64'd0;
        m1_rdata    = 64'd0;
        m0_rerr     = 1'b0;
        m1_rerr     = 1'b0;
        tmr_cen_o   = 1'b0;
        tmr_wen_o   = 1'b0;
        tmr_addr_o  = '0;
        tmr_wdata_o = 64'd0;
        if (rst_n) begin
            case (state_q)
                ACCESS: begin
                    m0_gnt      = ~win_q;
                    m1_gnt      = win_q;
                    tmr_cen_o   = mapped;
                    tmr_wen_o   = mapped & we_q;
                    tmr_addr_o  = addr_q;
                    tmr_wdata_o = wdata_q;
                end
                RESP: begin
                    if (win_q) begin
                        m1_rvalid = 1'b1;
                        m1_rdata  = resp_q;
                        m1_rerr   = rerr_q;
                    end else begin
                        m0_rvalid = 1'b1;
                        m0_rdata  = resp_q;
                        m0_rerr   = rerr_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_arbiter.sv
// Directed testbench for clint_arbiter: writes, reads, unmapped addresses,
// tie-breaking under continuous contention, and reset during ACCESS.

`ifndef ADDR_MTIMECMP
`define ADDR_MTIMECMP 64'h0000_0000_0200_4000
`endif
`ifndef ADDR_MTIME
`define ADDR_MTIME 64'h0000_0000_0200_BFF8
`endif

module tb_clint_arbiter;

  localparam logic [63:0] A_MTIME    = `ADDR_MTIME;
  localparam logic [63:0] A_MTIMECMP = `ADDR_MTIMECMP;
  localparam logic [63:0] A_UNMAP    = 64'h0000_0000_0200_0010;
  localparam logic [63:0] A_ALIAS    = `ADDR_MTIME | 64'h0000_0100_0000_0000;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [63:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [63:0] m1_addr = '0, m1_wdata = '0;
  logic [63:0] tmr_rdata_i = '0;
  logic        m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
  logic [63:0] m0_rdata, m1_rdata;
  logic        tmr_cen_o, tmr_wen_o;
  logic [63:0] tmr_addr_o, tmr_wdata_o;
  logic [1:0]  fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  clint_arbiter #(.ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
    .tmr_cen_o(tmr_cen_o), .tmr_wen_o(tmr_wen_o), .tmr_addr_o(tmr_addr_o),
    .tmr_wdata_o(tmr_wdata_o), .tmr_rdata_i(tmr_rdata_i),
    .fsm_state(fsm_state)
  );

  // driver: advance one cycle, then settle away from the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // all requester/timer outputs idle
  task automatic check_quiet(input string tag);
    check({tag, " m0_gnt"}, {63'd0, m0_gnt}, 64'd0);
    check({tag, " m1_gnt"}, {63'd0, m1_gnt}, 64'd0);
    check({tag, " m0_rvalid"}, {63'd0, m0_rvalid}, 64'd0);
    check({tag, " m1_rvalid"}, {63'd0, m1_rvalid}, 64'd0);
    check({tag, " m0_rdata"}, m0_rdata, 64'd0);
    check({tag, " m1_rdata"}, m1_rdata, 64'd0);
    check({tag, " cen"}, {63'd0, tmr_cen_o}, 64'd0);
    check({tag, " wen"}, {63'd0, tmr_wen_o}, 64'd0);
  endtask

  logic exp_win [4];

  initial begin
`ifdef CLINT_ARB_RR_EN
    exp_win = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_win = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // reset state
    tick();
    tick();
    check("rst state", {62'd0, fsm_state}, 64'd0);
    check_quiet("rst");
    check("rst addr", tmr_addr_o, 64'd0);
    check("rst wdata", tmr_wdata_o, 64'd0);
    rst_n = 1'b1;
    tick();

    // m0 write MTIMECMP = 0x100
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = A_MTIMECMP; m0_wdata = 64'h100;
    tick();
    check("wr gnt", {63'd0, m0_gnt}, 64'd1);
    check("wr m1_gnt", {63'd0, m1_gnt}, 64'd0);
    check("wr cen", {63'd0, tmr_cen_o}, 64'd1);
    check("wr wen", {63'd0, tmr_wen_o}, 64'd1);
    check("wr addr", tmr_addr_o, A_MTIMECMP);
    check("wr wdata", tmr_wdata_o, 64'h100);
    check("wr early rvalid", {63'd0, m0_rvalid}, 64'd0);
    m0_req = 1'b0;
    tick();
    check("wr rvalid", {63'd0, m0_rvalid}, 64'd1);
    check("wr rerr", {63'd0, m0_rerr}, 64'd0);
    check("wr rdata", m0_rdata, 64'd0);
    check("wr gnt gone", {63'd0, m0_gnt}, 64'd0);
    check("wr cen gone", {63'd0, tmr_cen_o}, 64'd0);
    tick();
    check_quiet("wr done");

    // m1 read MTIME, timer returns 0x55 during ACCESS
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = A_MTIME; m1_wdata = 64'hdead;
    tmr_rdata_i = 64'h55;
    tick();
    check("rd gnt", {63'd0, m1_gnt}, 64'd1);
    check("rd cen", {63'd0, tmr_cen_o}, 64'd1);
    check("rd wen", {63'd0, tmr_wen_o}, 64'd0);
    check("rd addr", tmr_addr_o, A_MTIME);
    m1_req = 1'b0;
    tick();
    tmr_rdata_i = 64'hffff_0000_ffff_0000;
    #1;
    check("rd rvalid", {63'd0, m1_rvalid}, 64'd1);
    check("rd rdata", m1_rdata, 64'h55);
    check("rd rerr", {63'd0, m1_rerr}, 64'd0);
    check("rd m0_rvalid", {63'd0, m0_rvalid}, 64'd0);
    check("rd m0_rdata", m0_rdata, 64'd0);
    check("rd m0_rerr", {63'd0, m0_rerr}, 64'd0);
    tick();
    check_quiet("rd done");

    // m0 read of unmapped address
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = A_UNMAP;
    tmr_rdata_i = 64'hdead_beef;
    tick();
    check("unm gnt", {63'd0, m0_gnt}, 64'd1);
    check("unm cen", {63'd0, tmr_cen_o}, 64'd0);
    m0_req = 1'b0;
    tick();
    check("unm rvalid", {63'd0, m0_rvalid}, 64'd1);
    check("unm rerr", {63'd0, m0_rerr}, 64'd1);
    check("unm rdata", m0_rdata, 64'd0);
    tick();

    // upper-bit alias of MTIME, written by m1: unmapped, no timer write
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = A_ALIAS; m1_wdata = 64'h7;
    tick();
    check("alias cen", {63'd0, tmr_cen_o}, 64'd0);
    check("alias wen", {63'd0, tmr_wen_o}, 64'd0);
    m1_req = 1'b0;
    tick();
    check("alias rvalid", {63'd0, m1_rvalid}, 64'd1);
    check("alias rerr", {63'd0, m1_rerr}, 64'd1);
    check("alias rdata", m1_rdata, 64'd0);
    tick();

    // fresh reset so the tie-break pointer starts at m0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // continuous contention: four transactions, grants every third cycle
    tmr_rdata_i = 64'h1234;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = A_MTIME;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = A_MTIMECMP;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("tie%0d m0_gnt", i), {63'd0, m0_gnt}, {63'd0, ~exp_win[i]});
      check($sformatf("tie%0d m1_gnt", i), {63'd0, m1_gnt}, {63'd0, exp_win[i]});
      if (i == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      tick();
      check($sformatf("tie%0d m0_rvalid", i), {63'd0, m0_rvalid}, {63'd0, ~exp_win[i]});
      check($sformatf("tie%0d m1_rvalid", i), {63'd0, m1_rvalid}, {63'd0, exp_win[i]});
      check($sformatf("tie%0d rdata", i), exp_win[i] ? m1_rdata : m0_rdata, 64'h1234);
      tick();
      check($sformatf("tie%0d idle", i), {62'd0, fsm_state}, 64'd0);
    end
    tick();

    // reset asserted during ACCESS of a write
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = A_MTIME; m0_wdata = 64'h5;
    tick();
    check("abort state", {62'd0, fsm_state}, 64'd1);
    rst_n = 1'b0;
    m0_req = 1'b0;
    #1;
    check("abort wen", {63'd0, tmr_wen_o}, 64'd0);
    check("abort cen", {63'd0, tmr_cen_o}, 64'd0);
    tick();
    check("abort idle", {62'd0, fsm_state}, 64'd0);
    check_quiet("abort next");
    rst_n = 1'b1;
    tick();
    check("abort still idle", {62'd0, fsm_state}, 64'd0);
    check("abort no rvalid", {63'd0, m0_rvalid}, 64'd0);

    // fresh request completes in three cycles
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = A_MTIMECMP; m1_wdata = 64'h42;
    tick();
    check("fresh gnt", {63'd0, m1_gnt}, 64'd1);
    check("fresh wen", {63'd0, tmr_wen_o}, 64'd1);
    check("fresh wdata", tmr_wdata_o, 64'h42);
    m1_req = 1'b0;
    tick();
    check("fresh rvalid", {63'd0, m1_rvalid}, 64'd1);
    check("fresh rerr", {63'd0, m1_rerr}, 64'd0);
    tick();
    check("fresh idle", {62'd0, fsm_state}, 64'd0);
    check_quiet("fresh done");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clint_arbiter.md
CLINT_ARBITER -- requirements
Module: clint_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 64, width of requester and timer address buses.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports, for each requester k in {0,1}:
- mk_req  input  1  request.
- mk_we  input  1  1=write, 0=read.
- mk_addr  input  ADDR_W  address.
- mk_wdata  input  64  write data.
REQ-005 SHALL have ports, for each requester k in {0,1}:
- mk_gnt  output  1  one-cycle grant pulse.
- mk_rvalid  output  1  one-cycle response pulse.
- mk_rdata  output  64  read data.
- mk_rerr  output  1  unmapped-address error.
REQ-006 SHALL have timer-side ports:
- tmr_cen_o  output  1  timer select.
- tmr_wen_o  output  1  timer write.
- tmr_addr_o  output  64  timer address.
- tmr_wdata_o  output  64  timer write data.
- tmr_rdata_i  input  64  combinational timer read data.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-008 SHALL define IDLE behaviour: if any mk_req=1, select winner per REQ-013/REQ-014, latch its we/addr/wdata, and go to ACCESS; else stay in IDLE.
REQ-009 SHALL define ACCESS behaviour (exactly one cycle): pulse winner mk_gnt=1, drive latched fields on tmr_*, sample tmr_rdata_i into a response register, then go to RESP.
REQ-010 SHALL assert tmr_cen_o=1 in ACCESS only when latched address equals `ADDR_MTIME or `ADDR_MTIMECMP, and tmr_wen_o=tmr_cen_o AND latched we; both SHALL be 0 in every other cycle, so the timer counts freely outside accesses.
REQ-011 SHALL define RESP behaviour (exactly one cycle): pulse winner mk_rvalid=1 with mk_rdata=response register (0 for writes), mk_rerr=1 if address unmapped (then mk_rdata=0), then return to IDLE.
REQ-012 SHALL fix latency: req sampled in IDLE at cycle N -> gnt at N+1 -> rvalid at N+2 -> next arbitration at N+3; peak throughput one transaction per 3 cycles.
REQ-013 SHALL require requesters to hold mk_req and payload stable until mk_gnt; deasserting before gnt withdraws the request with no response; the loser keeps waiting.
REQ-014 SHALL resolve simultaneous m0_req and m1_req per Configuration; a single requester always wins immediately.
REQ-015 SHALL hold non-winner gnt/rvalid/rerr at 0 and mk_rdata at 0 whenever mk_rvalid=0.
REQ-016 SHALL use the unmapped path for addresses differing from both timer addresses, including upper-bit aliases.

Reset
REQ-017 SHALL, on rst_n=0 at a clock edge: FSM->IDLE, all gnt/rvalid/rerr=0, all rdata=0, tmr_cen_o=tmr_wen_o=0, tmr_addr_o=tmr_wdata_o=0, round-robin pointer->m0 preferred.
REQ-018 SHALL abort any in-flight transaction on reset in ACCESS or RESP: no rvalid issued, and no timer write occurs in the reset cycle.

Configuration
REQ-019 SHALL use macro CLINT_ARB_RR_EN: when defined, round-robin (on a tie, the requester not granted last wins; pointer updates on each grant); when undefined, fixed priority with m0 always winning ties and no pointer register.

Verification
REQ-020 SHALL cover m0 write `ADDR_MTIMECMP=64'h100 -> m0_gnt at N+1 with tmr_cen_o=tmr_wen_o=1 and tmr_wdata_o=64'h100, m0_rvalid at N+2 with rerr=0, rdata=0.
REQ-021 SHALL cover m1 read `ADDR_MTIME while timer returns 64'h55 in ACCESS -> m1_rvalid at N+2, m1_rdata=64'h55, m0 outputs all 0.
REQ-022 SHALL cover both requesting continuously for 4 transactions -> RR_EN grant order m0,m1,m0,m1; without RR_EN m0,m0,m0,m0.
REQ-023 SHALL cover m0 read of address 64'h0200_0010 (unmapped) -> tmr_cen_o stays 0, m0_rvalid=1, m0_rerr=1, m0_rdata=0.
REQ-024 SHALL cover rst_n=0 during ACCESS of a write -> no rvalid, FSM in IDLE next cycle, tmr_wen_o=0 in the reset cycle, then a fresh request completes normally in 3 cycles.
